fpdiv_seq_ctrl: RTL and testbench
=================================

# fpdiv_seq_ctrl

Sequencing controller for the iterative floating-point divide/square-root unit. It sits directly downstream of the divider exception-classification stage and consumes its result type and flags. Special cases (NaN, Inf, zero, divide-by-zero) bypass the datapath with a canonical double-precision result. Normal operands run a counted recurrence, then a rounding cycle, and the result is presented under a valid/ack handshake.

## Interface
- DIV_ITERS, 28: recurrence cycles for divide, ≥1
- SQRT_ITERS, 28: recurrence cycles for square root, ≥1
- CNT_W, 6: iteration counter width; must hold max(DIV_ITERS, SQRT_ITERS)-1
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  operation request; accepted only when ready=1
- ready  out  1  controller idle, can accept start
- op_type  in  1  0=divide, 1=sqrt; sampled on accept
- Ztype  in  3  classification: 000 normal, 001 QNaN, 010 Inf, 011 Zero, bit2=divide-by-zero; sampled on accept
- Invalid  in  1  invalid-operation exception; sampled on accept
- NaNIn  in  1  either operand is NaN; sampled on accept
- Denorm  in  1  denormal input present; sampled on accept
- SignA, SignB  in  1  operand signs; sampled on accept
- flush  in  1  abort the current operation
- prep_en  out  1  datapath denormal-normalize cycle
- iter_en  out  1  advance the recurrence datapath
- iter_first  out  1  first recurrence cycle; datapath loads operands
- round_en  out  1  datapath rounding cycle
- result_valid  out  1  result and flags available
- result_ack  in  1  consumer accepts the result
- special  out  1  result is SpecialResult; the datapath output is ignored
- SpecialResult  out  64  canonical special-case result
- FlagNV  out  1  invalid flag, valid with result_valid
- FlagDZ  out  1  divide-by-zero flag, valid with result_valid
- op_q  out  1  latched op_type

## Operation
- States: IDLE, PREP, ITER, ROUND, HOLD. ready=1 only in IDLE.
- An accept occurs when start=1 in IDLE. On accept, latch op_type, Ztype, Invalid, NaNIn, Denorm and the signs.
- Special decode, in priority order:
  - NaN if Invalid | NaNIn | Ztype[1:0]==01 → SpecialResult 0x7FF8_0000_0000_0000.
  - Else Inf if Ztype[1:0]==10 → sign s, exponent all ones, mantissa 0.
  - Else Zero if Ztype[1:0]==11 → sign s, rest 0.
  - special = any of the three.
- Sign s = SignA^SignB for divide, SignA for sqrt.
- FlagNV = Invalid.
- FlagDZ = Ztype[2] & ~op_type & ~NaN-case.
- For a normal result, SpecialResult=0, special=0, FlagDZ=0 and FlagNV=Invalid (which is 0 in this case).
- Transitions:
  - IDLE→HOLD on a special accept.
  - IDLE→PREP on a normal accept with Denorm.
  - IDLE→ITER on a normal accept without Denorm.
  - PREP→ITER after 1 cycle.
  - ITER→ROUND when cnt==0.
  - ROUND→HOLD after 1 cycle.
  - HOLD→IDLE when result_ack=1.
- Counter: on entry to ITER, cnt = N-1, where N = DIV_ITERS if op_q=0, else SQRT_ITERS. It decrements each ITER cycle.
- iter_first=1 only on the first ITER cycle.
- prep_en, iter_en, round_en and result_valid are decoded from state (PREP, ITER, ROUND, HOLD respectively).
- special, SpecialResult, FlagNV and FlagDZ are registered on accept and held stable until the next accept.

## Timing
- Reset (asynchronous): state=IDLE, cnt=0, all latched fields 0.
  - Outputs during reset: ready=1; all other outputs 0, including SpecialResult=0.
- Latency from accept edge (cycle 0) to first result_valid cycle:
  - special: 1
  - normal: N+2
  - normal with Denorm: N+3
- result_valid stays high until result_ack is sampled high. The result and flags must not change while valid is high.
- Ack in the same cycle valid rises completes the transfer. valid=0 and ready=1 on the next cycle.
- start while not in IDLE is ignored. It is not queued.
- start and result_ack together in HOLD: ack completes, start is dropped. An accept needs a new start in IDLE.
- result_ack outside HOLD has no effect.
- flush=1 in any state: next state is IDLE and cnt=0.
  - No result_valid is produced; the latched flags are kept.
  - flush has priority over result_ack and over start.
  - A start during a flush cycle is not accepted.
- Reset mid-operation aborts immediately. No result_valid is produced.

## Test plan
- Reset asserted during ITER → immediately state IDLE, ready=1, result_valid=0, iter_en=0. After release, a normal divide with result_ack tied high gives result_valid at cycle 30.
- Divide, Ztype=110, Invalid=0, SignA=1, SignB=0 → result_valid at cycle 1 with special=1.
  - SpecialResult=0xFFF0_0000_0000_0000, FlagDZ=1, FlagNV=0.
  - result_ack is held low for 5 cycles; outputs are stable throughout.
- Sqrt, Invalid=1 → special=1, SpecialResult=0x7FF8_0000_0000_0000, FlagNV=1, FlagDZ=0.
- Sqrt, Ztype=011, SignA=1 → SpecialResult=0x8000_0000_0000_0000.
- Normal divide, Denorm=1, DIV_ITERS=28:
  - prep_en in cycle 1; iter_en in cycles 2–29, iter_first in cycle 2; round_en in cycle 30.
  - result_valid in cycle 31, special=0.
  - Repeat with Denorm=0 → result_valid in cycle 30.
- Normal sqrt with SQRT_ITERS=5:
  - flush in the 3rd ITER cycle → IDLE next cycle, no result_valid.
  - start asserted in HOLD alongside result_ack → ignored; ready=1 the next cycle.

Source files
------------

// File: rtl/fpdiv_seq_ctrl.sv
// Sequencing controller for the iterative FP divide/sqrt unit: special-case bypass,
// counted recurrence, rounding cycle and a valid/ack result handshake.
module fpdiv_seq_ctrl #(
  parameter int DIV_ITERS  = 28,
  parameter int SQRT_ITERS = 28,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic        op_type,
  input  logic [2:0]  Ztype,
  input  logic        Invalid,
  input  logic        NaNIn,
  input  logic        Denorm,
  input  logic        SignA,
  input  logic        SignB,
  input  logic        flush,
  output logic        prep_en,
  output logic        iter_en,
  output logic        iter_first,
  output logic        round_en,
  output logic        result_valid,
  input  logic        result_ack,
  output logic        special,
  output logic [63:0] SpecialResult,
  output logic        FlagNV,
  output logic        FlagDZ,
  output logic        op_q
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PREP  = 3'd1;
  localparam logic [2:0] ITER  = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_ITERS - 1);
  localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_ITERS - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             special_q, nv_q, dz_q;
  logic [63:0]      result_q;

  logic             accept;
  logic             case_nan, case_inf, case_zero, is_special, res_sign, dz_dec;
  logic [63:0]      spec_dec;

  // Special-case decode on the live inputs; only captured on an accept.
  always_comb begin
    case_nan   = Invalid | NaNIn | (Ztype[1:0] == 2'b01);
    case_inf   = ~case_nan & (Ztype[1:0] == 2'b10);
    case_zero  = ~case_nan & (Ztype[1:0] == 2'b11);
    is_special = case_nan | case_inf | case_zero;
    res_sign   = op_type ? SignA : (SignA ^ SignB);
    dz_dec     = Ztype[2] & ~op_type & ~case_nan & is_special;
    spec_dec   = 64'd0;
    if (case_nan) begin
      spec_dec = 64'h7FF8_0000_0000_0000;
    end else if (case_inf) begin
      spec_dec = {res_sign, 11'h7FF, 52'd0};
    end else if (case_zero) begin
      spec_dec = {res_sign, 63'd0};
    end
  end

  assign accept = start & (state_q == IDLE) & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_special) begin
              state_d = HOLD;
            end else if (Denorm) begin
              state_d = PREP;
            end else begin
              state_d = ITER;
              cnt_d   = op_type ? SQRT_LOAD : DIV_LOAD;
              first_d = 1'b1;
            end
          end
        end
        PREP: begin
          state_d = ITER;
          cnt_d   = op_q ? SQRT_LOAD : DIV_LOAD;
          first_d = 1'b1;
        end
        ITER: begin
          if (cnt_q == '0) begin
            state_d = ROUND;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ROUND: state_d = HOLD;
        HOLD: begin
          if (result_ack) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Result fields stay frozen from one accept to the next, flushes included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 1'b0;
      special_q <= 1'b0;
      result_q  <= 64'd0;
      nv_q      <= 1'b0;
      dz_q      <= 1'b0;
    end else if (accept) begin
      op_q      <= op_type;
      special_q <= is_special;
      result_q  <= spec_dec;
      nv_q      <= Invalid;
      dz_q      <= dz_dec;
    end
  end

  assign ready         = (state_q == IDLE);
  assign prep_en       = (state_q == PREP);
  assign iter_en       = (state_q == ITER);
  assign iter_first    = (state_q == ITER) & first_q;
  assign round_en      = (state_q == ROUND);
  assign result_valid  = (state_q == HOLD);
  assign special       = special_q;
  assign SpecialResult = result_q;
  assign FlagNV        = nv_q;
  assign FlagDZ        = dz_q;

endmodule

// File: tb/tb_fpdiv_seq_ctrl.sv
// Scoreboard bench for fpdiv_seq_ctrl: stimulus pushes expected results, a negedge
// monitor pops and compares them whenever result_valid rises.
module tb_fpdiv_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ready;
  logic        op_type = 1'b0;
  logic [2:0]  Ztype = 3'b000;
  logic        Invalid = 1'b0;
  logic        NaNIn = 1'b0;
  logic        Denorm = 1'b0;
  logic        SignA = 1'b0;
  logic        SignB = 1'b0;
  logic        flush = 1'b0;
  logic        prep_en, iter_en, iter_first, round_en, result_valid;
  logic        result_ack = 1'b0;
  logic        special;
  logic [63:0] SpecialResult;
  logic        FlagNV, FlagDZ, op_q;

  fpdiv_seq_ctrl #(.DIV_ITERS(28), .SQRT_ITERS(5), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .op_type(op_type),
    .Ztype(Ztype), .Invalid(Invalid), .NaNIn(NaNIn), .Denorm(Denorm),
    .SignA(SignA), .SignB(SignB), .flush(flush), .prep_en(prep_en),
    .iter_en(iter_en), .iter_first(iter_first), .round_en(round_en),
    .result_valid(result_valid), .result_ack(result_ack), .special(special),
    .SpecialResult(SpecialResult), .FlagNV(FlagNV), .FlagDZ(FlagDZ), .op_q(op_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        sp;
    logic [63:0] res;
    logic        nv;
    logic        dz;
    logic        op;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: compare on the first valid cycle, then check stability while held.
  exp_t cur;
  bit   in_hold = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      in_hold <= 1'b0;
    end else if (result_valid) begin
      if (!in_hold) begin
        in_hold <= 1'b1;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'(result_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          cur <= e;
          chk("latency", 64'(cyc), 64'(e.cyc));
          chk("special", 64'(special), 64'(e.sp));
          chk("SpecialResult", SpecialResult, e.res);
          chk("FlagNV", 64'(FlagNV), 64'(e.nv));
          chk("FlagDZ", 64'(FlagDZ), 64'(e.dz));
          chk("op_q", 64'(op_q), 64'(e.op));
        end
      end else begin
        chk("hold_SpecialResult", SpecialResult, cur.res);
        chk("hold_special", 64'(special), 64'(cur.sp));
        chk("hold_flags", {62'd0, FlagNV, FlagDZ}, {62'd0, cur.nv, cur.dz});
      end
    end else begin
      in_hold <= 1'b0;
    end
  end

  // Waits for ready, issues one accept and (optionally) queues its expected result.
  task automatic do_op(input bit op, input logic [2:0] z, input bit inv, input bit nan,
                       input bit den, input bit sa, input bit sb_in, input bit push,
                       input bit sp, input logic [63:0] res, input bit nv, input bit dz,
                       input int lat);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_start", 64'(ready), 64'd1);
    op_type = op; Ztype = z; Invalid = inv; NaNIn = nan; Denorm = den;
    SignA = sa; SignB = sb_in; start = 1'b1;
    if (push) begin
      e.cyc = cyc + lat; e.sp = sp; e.res = res; e.nv = nv; e.dz = dz; e.op = op;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic ack_result(input int hold, input bit with_start);
    int n = 0;
    @(negedge clk);
    while (!result_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 64'(result_valid), 64'd1);
    repeat (hold) @(negedge clk);
    result_ack = 1'b1;
    if (with_start) begin
      start = 1'b1; Invalid = 1'b1;
    end
    @(negedge clk);
    result_ack = 1'b0; start = 1'b0; Invalid = 1'b0;
    chk("ready_after_ack", 64'(ready), 64'd1);
    chk("valid_after_ack", 64'(result_valid), 64'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_outputs", {57'd0, prep_en, iter_en, iter_first, round_en, result_valid, special, op_q},
        64'd0);
    chk("rst_SpecialResult", SpecialResult, 64'd0);
    chk("rst_flags", {62'd0, FlagNV, FlagDZ}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during ITER aborts at once.
    do_op(1'b0, 3'b000, 0, 0, 0, 0, 0, 1'b0, 0, 64'd0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("pre_reset_iter_en", 64'(iter_en), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_valid", 64'(result_valid), 64'd0);
    chk("midrst_iter_en", 64'(iter_en), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Normal divide with ack tied high: valid at cycle 30.
    result_ack = 1'b1;
    do_op(1'b0, 3'b000, 0, 0, 0, 1, 1, 1'b1, 0, 64'd0, 0, 0, 30);
    ack_result(0, 1'b0);

    // Divide by zero to infinity, ack held off for 5 cycles.
    do_op(1'b0, 3'b110, 0, 0, 0, 1, 0, 1'b1, 1, 64'hFFF0_0000_0000_0000, 0, 1, 1);
    ack_result(5, 1'b0);
    do_op(1'b1, 3'b000, 1, 0, 0, 0, 0, 1'b1, 1, 64'h7FF8_0000_0000_0000, 1, 0, 1);
    ack_result(0, 1'b0);
    do_op(1'b1, 3'b011, 0, 0, 0, 1, 0, 1'b1, 1, 64'h8000_0000_0000_0000, 0, 0, 1);
    ack_result(1, 1'b0);
    do_op(1'b1, 3'b110, 0, 0, 0, 0, 1, 1'b1, 1, 64'h7FF0_0000_0000_0000, 0, 0, 1);
    ack_result(0, 1'b0);
    do_op(1'b0, 3'b111, 0, 0, 0, 0, 1, 1'b1, 1, 64'h8000_0000_0000_0000, 0, 1, 1);
    ack_result(0, 1'b0);
    do_op(1'b0, 3'b101, 0, 0, 0, 1, 1, 1'b1, 1, 64'h7FF8_0000_0000_0000, 0, 0, 1);
    ack_result(0, 1'b0);
    do_op(1'b0, 3'b010, 0, 1, 0, 0, 0, 1'b1, 1, 64'h7FF8_0000_0000_0000, 0, 0, 1);
    ack_result(0, 1'b0);

    // Denormal divide: strobe schedule through the rounding cycle.
    do_op(1'b0, 3'b000, 0, 0, 1, 0, 0, 1'b1, 0, 64'd0, 0, 0, 31);
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      chk($sformatf("strobes_c%0d", j), {60'd0, prep_en, iter_en, iter_first, round_en},
          {60'd0, 1'(j == 1), 1'(j >= 2 && j <= 29), 1'(j == 2), 1'(j == 30)});
    end
    ack_result(0, 1'b0);

    // Divide-by-zero class bit on a normal operand leaves FlagDZ clear.
    do_op(1'b0, 3'b100, 0, 0, 0, 0, 0, 1'b1, 0, 64'd0, 0, 0, 30);
    ack_result(0, 1'b0);

    // Flush in the third ITER cycle of a 5-iteration sqrt.
    do_op(1'b1, 3'b000, 0, 0, 0, 0, 0, 1'b0, 0, 64'd0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("flush_iter_en", 64'(iter_en), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", 64'(ready), 64'd1);
    chk("flush_iter_en_off", 64'(iter_en), 64'd0);
    repeat (10) @(negedge clk);
    chk("flush_no_valid", 64'(result_valid), 64'd0);

    // Start during a flush cycle is not accepted.
    start = 1'b1; flush = 1'b1; Denorm = 1'b0; Ztype = 3'b000; Invalid = 1'b0; NaNIn = 1'b0;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_ready", 64'(ready), 64'd1);
    chk("flush_start_iter", {62'd0, prep_en, iter_en}, 64'd0);

    // Start alongside ack in HOLD is dropped.
    do_op(1'b1, 3'b000, 0, 0, 0, 1, 0, 1'b1, 0, 64'd0, 0, 0, 7);
    ack_result(0, 1'b1);
    @(negedge clk);
    chk("hold_start_dropped_ready", 64'(ready), 64'd1);
    chk("hold_start_dropped_valid", 64'(result_valid), 64'd0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
